cs_y_packer: RTL and testbench

- Downstream stage of the CS filter; consumes the 10-bit Y stream, one sample per clock, gated by a valid strobe.
- Buffers samples in a small FIFO.
- Bit-packs every 4 samples (40 bits) into 5 bytes.
- Delivers bytes over a valid/ready byte interface to the output writer or serial link, with group framing, a flush, and a sticky overflow flag.

---
 rtl/cs_y_packer.sv | 120 ++++++++++++
 tb/tb_cs_y_packer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_y_packer.sv
// Y-stream packer: buffers 10-bit samples in a FIFO and bit-packs them LSB first
// into 5-byte groups on a valid/ready byte interface, with flush and sticky overflow.
module cs_y_packer #(
    parameter int DEPTH = 8,
    parameter int LW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    y_in,
    input  logic          y_valid,
    input  logic          flush,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic [17:0]   acc;
    logic [4:0]    cnt;
    logic [2:0]    byte_idx;
    logic          flush_pending;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          fire;
    logic          flush_emit;
    logic [17:0]   acc_s;
    logic [4:0]    cnt_s;
    logic [17:0]   acc_n;
    logic [4:0]    cnt_n;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(DEPTH));
    assign push       = y_valid && !fifo_full;

    // A flush byte is only shown once every queued sample has entered acc.
    assign flush_emit = flush_pending && fifo_empty && (cnt != 5'd0) && (cnt < 5'd8);

    assign dout_valid = (cnt >= 5'd8) || flush_emit;
    assign dout       = acc[7:0];
    assign dout_last  = flush_emit || ((cnt >= 5'd8) && (byte_idx == 3'd4));
    assign fire       = dout_valid && dout_ready;
    assign fifo_level = level;

    always_comb begin
        acc_s = acc;
        cnt_s = cnt;
        if (fire) begin
            acc_s = acc >> 8;
            cnt_s = flush_emit ? 5'd0 : (cnt - 5'd8);
        end
        pop   = (cnt_s < 5'd8) && !fifo_empty && !flush_emit;
        acc_n = acc_s;
        cnt_n = cnt_s;
        if (pop) begin
            acc_n = acc_s | ({8'b0, mem[rd_ptr]} << cnt_s);
            cnt_n = cnt_s + 5'd10;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            acc           <= '0;
            cnt           <= '0;
            byte_idx      <= '0;
            flush_pending <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end

            acc <= acc_n;
            cnt <= cnt_n;

            if (fire) begin
                if (flush_emit || (byte_idx == 3'd4)) begin
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end

            flush_pending <= flush || (flush_pending && !(fifo_empty && (cnt == 5'd0)));

            if (y_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cs_y_packer.sv
// Scoreboard bench for cs_y_packer: a bit-queue reference model predicts the byte
// stream; a monitor checks every accepted byte against it.
module tb_cs_y_packer;

    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    y_in;
    logic          y_valid;
    logic          flush;
    logic [7:0]    dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] exp_q[$];
    bit         mbits[$];
    int         mgrp = 0;
    logic [9:0] smp[10];

    always #5 clk = ~clk;

    cs_y_packer #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: accepted samples become a flat LSB-first bit stream cut into bytes.
    function automatic void model_push(input logic [9:0] s);
        logic [7:0] b;
        for (int i = 0; i < 10; i++) mbits.push_back(s[i]);
        while (mbits.size() >= 8) begin
            for (int i = 0; i < 8; i++) b[i] = mbits.pop_front();
            exp_q.push_back({(mgrp == 4), b});
            mgrp = (mgrp + 1) % 5;
        end
    endfunction

    function automatic void model_flush();
        logic [7:0] b;
        b = '0;
        if (mbits.size() > 0) begin
            for (int i = 0; i < mbits.size(); i++) b[i] = mbits[i];
            mbits.delete();
            exp_q.push_back({1'b1, b});
            mgrp = 0;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        mbits.delete();
        mgrp = 0;
    endfunction

    always @(negedge clk) begin
        logic [8:0] e;
        if (reset === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %0h last=%0b, expected no byte (t=%0t)",
                         dout, dout_last, $time);
            end else begin
                e = exp_q.pop_front();
                check("byte{last,dout}", {23'd0, dout_last, dout}, {23'd0, e});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_s(input logic [9:0] s, input bit accept);
        y_in    = s;
        y_valid = 1'b1;
        if (accept) model_push(s);
        cyc(1);
        y_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        model_flush();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            cyc(1);
            n++;
        end
        check(name, exp_q.size(), 0);
        cyc(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int guard;
        reset      = 1'b0;
        y_in       = '0;
        y_valid    = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b0;
        cyc(2);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_last", dout_last, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b1;
        cyc(1);

        // group framing
        dout_ready = 1'b1;
        push_s(10'h3FF, 1'b1);
        push_s(10'h000, 1'b1);
        push_s(10'h155, 1'b1);
        push_s(10'h2AA, 1'b1);
        wait_drain("group_drain");
        check("group_level", fifo_level, 0);
        check("group_overflow", overflow, 1'b0);

        // flush of a partial group, then a fresh group from index 0
        push_s(10'h123, 1'b1);
        cyc(2);
        do_flush();
        wait_drain("flush_drain");
        check("flush_valid_idle", dout_valid, 1'b0);
        for (int i = 0; i < 4; i++) push_s(10'($urandom), 1'b1);
        wait_drain("postflush_group");

        // backpressure and overflow
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            smp[i] = 10'($urandom);
            push_s(smp[i], (i < 9));
        end
        check("ovf_level", fifo_level, DEPTH);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_valid_held", dout_valid, 1'b1);
        check("ovf_dout_held", dout, {24'd0, smp[0][7:0]});
        cyc(3);
        check("ovf_dout_stable", {dout_valid, dout_last, dout}, {1'b1, 1'b0, smp[0][7:0]});
        dout_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", overflow, 1'b1);
        do_flush();
        wait_drain("ovf_flush");
        check("ovf_level_empty", fifo_level, 0);

        // push at full on a cycle that also pops
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_s(10'($urandom), 1'b1);
        check("full_level", fifo_level, DEPTH);
        check("full_no_ovf", overflow, 1'b0);
        dout_ready = 1'b1;
        push_s(10'($urandom), 1'b0);
        dout_ready = 1'b0;
        check("simul_level", fifo_level, DEPTH - 1);
        check("simul_ovf", overflow, 1'b1);
        dout_ready = 1'b1;
        wait_drain("simul_drain");
        do_flush();
        wait_drain("simul_flush");

        // randomized traffic with random backpressure
        do_reset();
        sent  = 0;
        guard = 0;
        while (sent < 400 && guard < 20000) begin
            dout_ready = 1'($urandom_range(0, 1));
            if (fifo_level < LW'(DEPTH - 1) && $urandom_range(0, 9) < 7) begin
                y_in    = 10'($urandom);
                y_valid = 1'b1;
                model_push(y_in);
                sent++;
            end else begin
                y_valid = 1'b0;
            end
            cyc(1);
            y_valid = 1'b0;
            guard++;
            if (sent == 200 && guard < 20000) begin
                dout_ready = 1'b1;
                wait_drain("rand_mid_drain");
                do_flush();
                wait_drain("rand_mid_flush");
                sent++;
            end
        end
        check("rand_sent", (sent >= 400), 1);
        dout_ready = 1'b1;
        wait_drain("rand_drain");
        do_flush();
        wait_drain("rand_flush");
        check("rand_overflow", overflow, 1'b0);
        check("rand_level", fifo_level, 0);

        // reset in the middle of buffered data
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_s(10'($urandom), 1'b1);
        check("mid_level", fifo_level, 3);
        check("mid_valid", dout_valid, 1'b1);
        reset = 1'b0;
        cyc(1);
        check("midrst_valid", dout_valid, 1'b0);
        check("midrst_level", fifo_level, 0);
        check("midrst_ovf", overflow, 1'b0);
        reset = 1'b1;
        model_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_s(10'($urandom), 1'b1);
        wait_drain("midrst_group");
        check("midrst_final_level", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
